// File: rtl/cascade_counter.sv
// Modulo-MODULUS up/down counter stage for synchronous cascades (shared clock, carry via ripple_in/ripple_out).
// Define CASCADE_COUNTER_OVERFLOW_EN to add the sticky overflow flag and its port.
module cascade_counter #(
  parameter int N_BITS  = 3,
  parameter int MODULUS = 8
) (
  input  logic              clk,
  input  logic              asyn_rst,
  input  logic              ripple_in,
  input  logic              load,
  input  logic [N_BITS-1:0] load_val,
  input  logic              up_dn,
  output logic [N_BITS-1:0] count,
`ifdef CASCADE_COUNTER_OVERFLOW_EN
  output logic              overflow,
`endif
  output logic              ripple_out
);

  // One guard bit so that MODULUS = 2**N_BITS still compares correctly.
  localparam int W = N_BITS + 1;
  localparam logic [N_BITS:0] TERM = W'(MODULUS - 1);
  localparam logic [N_BITS:0] ONE  = W'(1);

  logic [N_BITS:0] cnt_q;
  logic [N_BITS:0] cnt_nxt;
  logic [N_BITS:0] load_ext;
  logic [N_BITS:0] load_clamp;
  logic            at_term;
  logic            wrap;

  always_comb begin
    load_ext   = {1'b0, load_val};
    load_clamp = (load_ext > TERM) ? TERM : load_ext;
    at_term    = up_dn ? (cnt_q == TERM) : (cnt_q == '0);
    wrap       = ripple_in & ~load & at_term;
    cnt_nxt    = cnt_q;
    if (load) begin
      cnt_nxt = load_clamp;
    end else if (ripple_in) begin
      if (up_dn) cnt_nxt = at_term ? '0 : cnt_q + ONE;
      else       cnt_nxt = at_term ? TERM : cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or posedge asyn_rst) begin
    if (asyn_rst) cnt_q <= '0;
    else          cnt_q <= cnt_nxt;
  end

  assign count      = cnt_q[N_BITS-1:0];
  assign ripple_out = wrap;

`ifdef CASCADE_COUNTER_OVERFLOW_EN
  // Load clears the flag even when it suppresses a wrap on the same edge.
  always_ff @(posedge clk or posedge asyn_rst) begin
    if (asyn_rst)  overflow <= 1'b0;
    else if (load) overflow <= 1'b0;
    else if (wrap) overflow <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_cascade_counter.sv
// Self-checking bench for cascade_counter: vector table on a MODULUS=6 stage plus a two-stage MODULUS=8 chain.
// Overflow checks are compiled in only when CASCADE_COUNTER_OVERFLOW_EN is defined.
module tb_cascade_counter;

  typedef struct {
    logic       ld;
    logic [2:0] lv;
    logic       rin;
    logic       ud;
    logic       rip;
    logic [2:0] cnt;
    logic       ovf;
  } vec_t;

  logic       clk = 1'b0;
  logic       asyn_rst = 1'b1;
  logic       ripple_in = 1'b0;
  logic       load = 1'b0;
  logic [2:0] load_val = 3'd0;
  logic       up_dn = 1'b1;
  logic [2:0] count;
  logic       ripple_out;

  logic       ch_load = 1'b0;
  logic [2:0] ch_lv = 3'd0;
  logic       ch_up = 1'b1;
  logic       ch_rin0 = 1'b1;
  logic [2:0] cnt0, cnt1;
  logic       rip0, rip1;

`ifdef CASCADE_COUNTER_OVERFLOW_EN
  logic overflow, ovf0, ovf1;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs[21];
  vec_t exp_q[$];
  int   chain_q[$];

  always #5 clk = ~clk;

  cascade_counter #(.N_BITS(3), .MODULUS(6)) dut (
    .clk(clk), .asyn_rst(asyn_rst), .ripple_in(ripple_in), .load(load),
    .load_val(load_val), .up_dn(up_dn), .count(count),
`ifdef CASCADE_COUNTER_OVERFLOW_EN
    .overflow(overflow),
`endif
    .ripple_out(ripple_out)
  );

  cascade_counter #(.N_BITS(3), .MODULUS(8)) s0 (
    .clk(clk), .asyn_rst(asyn_rst), .ripple_in(ch_rin0), .load(ch_load),
    .load_val(ch_lv), .up_dn(ch_up), .count(cnt0),
`ifdef CASCADE_COUNTER_OVERFLOW_EN
    .overflow(ovf0),
`endif
    .ripple_out(rip0)
  );

  cascade_counter #(.N_BITS(3), .MODULUS(8)) s1 (
    .clk(clk), .asyn_rst(asyn_rst), .ripple_in(rip0), .load(ch_load),
    .load_val(ch_lv), .up_dn(ch_up), .count(cnt1),
`ifdef CASCADE_COUNTER_OVERFLOW_EN
    .overflow(ovf1),
`endif
    .ripple_out(rip1)
  );

  function automatic vec_t mk(logic ld, logic [2:0] lv, logic rin, logic ud,
                              logic rip, logic [2:0] cnt, logic ovf);
    vec_t v;
    v.ld = ld; v.lv = lv; v.rin = rin; v.ud = ud;
    v.rip = rip; v.cnt = cnt; v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs, check the combinational carry, then the registered result after the edge.
  task automatic step(input vec_t v, input string tag);
    vec_t e;
    load = v.ld; load_val = v.lv; ripple_in = v.rin; up_dn = v.ud;
    #1;
    chk({tag, " ripple_out"}, int'(ripple_out), int'(v.rip));
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, " count"}, int'(count), int'(e.cnt));
`ifdef CASCADE_COUNTER_OVERFLOW_EN
    chk({tag, " overflow"}, int'(overflow), int'(e.ovf));
`endif
  endtask

  initial begin
    // ld lv rin ud | rip cnt ovf
    vecs[0]  = mk(0, 0, 1, 1, 0, 1, 0);
    vecs[1]  = mk(0, 0, 1, 1, 0, 2, 0);
    vecs[2]  = mk(0, 0, 1, 1, 0, 3, 0);
    vecs[3]  = mk(0, 0, 1, 1, 0, 4, 0);
    vecs[4]  = mk(0, 0, 1, 1, 0, 5, 0);
    vecs[5]  = mk(0, 0, 1, 1, 1, 0, 1);
    vecs[6]  = mk(0, 0, 1, 1, 0, 1, 1);
    vecs[7]  = mk(0, 0, 1, 1, 0, 2, 1);
    vecs[8]  = mk(0, 0, 0, 1, 0, 2, 1);
    vecs[9]  = mk(1, 1, 1, 1, 0, 1, 0);
    vecs[10] = mk(0, 0, 1, 0, 0, 0, 0);
    vecs[11] = mk(0, 0, 1, 0, 1, 5, 1);
    vecs[12] = mk(1, 7, 1, 1, 0, 5, 0);
    vecs[13] = mk(0, 0, 0, 1, 0, 5, 0);
    vecs[14] = mk(0, 0, 1, 0, 0, 4, 0);
    vecs[15] = mk(1, 6, 0, 0, 0, 5, 0);
    vecs[16] = mk(1, 0, 1, 0, 0, 0, 0);
    vecs[17] = mk(0, 0, 1, 1, 0, 1, 0);
    vecs[18] = mk(0, 0, 1, 0, 0, 0, 0);
    vecs[19] = mk(0, 0, 0, 0, 0, 0, 0);
    vecs[20] = mk(0, 0, 1, 1, 0, 1, 0);

    // Reset state and reset behaviour
    #2;
    chk("rst count", int'(count), 0);
`ifdef CASCADE_COUNTER_OVERFLOW_EN
    chk("rst overflow", int'(overflow), 0);
`endif
    up_dn = 1'b0; ripple_in = 1'b1; load = 1'b0;
    #1;
    chk("rst ripple_out down", int'(ripple_out), 1);
    load = 1'b1; load_val = 3'd3;
    #1;
    chk("rst ripple_out load", int'(ripple_out), 0);
    @(posedge clk);
    #1;
    chk("rst ignores load", int'(count), 0);
    asyn_rst = 1'b0;
    load = 1'b0; up_dn = 1'b1;

    for (int i = 0; i < 21; i++) step(vecs[i], $sformatf("vec%0d", i));

    // Async reset pulsed between edges at count 4
    step(mk(0, 0, 1, 1, 0, 2, 0), "pre_rst a");
    step(mk(0, 0, 1, 1, 0, 3, 0), "pre_rst b");
    step(mk(0, 0, 1, 1, 0, 4, 0), "pre_rst c");
    #2;
    asyn_rst = 1'b1;
    #1;
    chk("mid rst count", int'(count), 0);
    asyn_rst = 1'b0;
    step(mk(0, 0, 1, 1, 0, 1, 0), "post_rst a");
    step(mk(0, 0, 1, 1, 0, 2, 0), "post_rst b");

    // Two chained MODULUS=8 stages
    asyn_rst = 1'b1;
    #1;
    asyn_rst = 1'b0;
    chk("chain rst", int'({cnt1, cnt0}), 0);
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("chain ripple %0d", i), int'(rip1), (i == 63) ? 1 : 0);
      chain_q.push_back((i + 1) % 64);
      @(posedge clk);
      #1;
      chk($sformatf("chain value %0d", i), int'({cnt1, cnt0}), chain_q.pop_front());
    end
`ifdef CASCADE_COUNTER_OVERFLOW_EN
    chk("chain s1 overflow", int'(ovf1), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cascade_counter.md
CASCADE_COUNTER -- requirements
Module: cascade_counter

Interface
REQ-001 SHALL have parameter N_BITS, default 3, counter width in bits.
REQ-002 SHALL have parameter MODULUS, default 8, count range 0..MODULUS-1; legal range 2..2**N_BITS.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port asyn_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ripple_in  input  1  count enable / carry-in from the upstream stage; tie to 1 for the first stage.
REQ-006 SHALL have port load  input  1  synchronous parallel load strobe.
REQ-007 SHALL have port load_val  input  N_BITS  value to load.
REQ-008 SHALL have port up_dn  input  1  direction: 1 = up, 0 = down.
REQ-009 SHALL have port count  output  N_BITS  current count, registered.
REQ-010 SHALL have port ripple_out  output  1  carry/borrow to the downstream stage's ripple_in.
REQ-011 SHALL have port overflow  output  1  sticky wrap flag; present only when the macro in REQ-031 is defined.

Function
REQ-012 SHALL apply per-cycle priority: load > ripple_in > hold.
REQ-013 SHALL, on load=1, set count to load_val on the next edge, regardless of ripple_in and up_dn.
REQ-014 SHALL clamp load_val >= MODULUS to MODULUS-1 when loading.
REQ-015 SHALL, on load=0, ripple_in=1, up_dn=1, advance count by 1; from MODULUS-1 it wraps to 0.
REQ-016 SHALL, on load=0, ripple_in=1, up_dn=0, decrement count by 1; from 0 it wraps to MODULUS-1.
REQ-017 SHALL hold count when load=0 and ripple_in=0.
REQ-018 SHALL drive ripple_out combinationally = ripple_in & !load & (up_dn ? count==MODULUS-1 : count==0).
REQ-019 SHALL make ripple_out high exactly in the cycle before a wrap edge, so that chained stages advance on the same edge (synchronous cascade, no ripple-clock).
REQ-020 SHALL keep ripple_out low whenever ripple_in=0, even at a terminal count.
REQ-021 SHALL have a latency of one clock from any input change to count.
REQ-022 SHALL apply a direction change only to the edge on which it is sampled; no extra wrap or skip results.
REQ-023 SHALL compute all arithmetic at N_BITS+1 bits internally, so that MODULUS = 2**N_BITS does not truncate the compare.

Reset
REQ-024 SHALL set count to 0 immediately when asyn_rst=1, independent of clk.
REQ-025 SHALL clear overflow (when present) to 0 on reset.
REQ-026 SHALL keep count at 0 and ignore load/ripple_in while asyn_rst=1.
REQ-027 SHALL hold ripple_out to its combinational value with count=0 during reset (high only if down-counting, ripple_in=1, load=0).
REQ-028 SHALL resume counting from 0 on the first edge after reset is released; reset asserted mid-count SHALL discard the count.

Configuration
REQ-029 SHALL set overflow on the edge on which a wrap occurs (either direction).
REQ-030 SHALL clear overflow on the edge on which load=1; if load and a wrap candidate occur together, load wins and overflow is cleared.
REQ-031 SHALL make macro CASCADE_COUNTER_OVERFLOW_EN control this feature: defined gives the overflow port plus the logic of REQ-029/REQ-030; undefined gives no overflow port and no flag register, with all other behaviour identical.

Verification
REQ-032 SHALL cover: N_BITS=3, MODULUS=6, up, ripple_in=1 for 8 edges from reset -> count 1,2,3,4,5,0,1,2; ripple_out high only while count=5.
REQ-033 SHALL cover: MODULUS=6, down from count=1, ripple_in=1 -> count 0 then 5; ripple_out high only while count=0.
REQ-034 SHALL cover: two stages chained (MODULUS=8 each, stage1.ripple_in=stage0.ripple_out), 64 edges -> combined value increments 0..63 then 0, with no skipped or doubled values.
REQ-035 SHALL cover: count=5 (MODULUS=6) with load=1, load_val=7, ripple_in=1 -> count=5 (clamped), ripple_out=0, overflow=0.
REQ-036 SHALL cover: asyn_rst pulsed between edges at count=4 -> count=0 before the next edge; counting restarts 1,2,...
REQ-037 SHALL cover (macro defined): wrap 5->0 -> overflow=1 and held through further counting until load=1, then 0; with macro undefined the bench compiles without the overflow port.
